// File: rtl/obstacle_frame_collector.sv
// rtl/obstacle_frame_collector.sv - per-frame obstacle word collector with ping-pong banks
module obstacle_frame_collector #(
  parameter int MAX_OBSTACLES  = 48,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int AW = $clog2(MAX_OBSTACLES + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_start,
  output logic          gen_activate,
  input  logic          gen_valid,
  input  logic          gen_first_row,
  input  logic [15:0]   gen_obstacle,
  input  logic          gen_done,
  input  logic [AW-1:0] rd_addr,
  output logic [15:0]   rd_data,
  output logic [AW-1:0] rd_count,
  output logic [8:0]    front_types,
  output logic          swap_pulse,
  output logic          busy,
  output logic          overflow,
  output logic          protocol_err
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, REQUEST, COLLECT, SWAP} state_t;
  state_t state, state_nx;

  logic [15:0]   bank0 [MAX_OBSTACLES];
  logic [15:0]   bank1 [MAX_OBSTACLES];
  logic          front_sel;
  logic [AW-1:0] wr_count;
  logic [TW-1:0] timer;
  logic [8:0]    shadow;

  logic [2:0] w_type;
  logic [1:0] w_lane;
  logic       lane_bad, bank_full, timeout, wr_en;

  assign w_type    = gen_obstacle[15:13];
  assign w_lane    = gen_obstacle[12:11];
  assign lane_bad  = (w_lane == 2'd3);
  assign bank_full = (wr_count >= AW'(MAX_OBSTACLES));
  assign timeout   = (timer == TW'(TIMEOUT_CYCLES - 1));
  assign wr_en     = (state == COLLECT) && gen_valid && !lane_bad && !bank_full;

  always_comb begin
    state_nx     = state;
    gen_activate = 1'b0;
    swap_pulse   = 1'b0;
    busy         = 1'b0;
    case (state)
      IDLE:    if (frame_start) state_nx = REQUEST;
      REQUEST: begin
        gen_activate = 1'b1;
        busy         = 1'b1;
        state_nx     = COLLECT;
      end
      COLLECT: begin
        busy = 1'b1;
        if (gen_done)     state_nx = SWAP;
        else if (timeout) state_nx = IDLE;
      end
      SWAP: begin
        swap_pulse = 1'b1;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      front_sel    <= 1'b0;
      wr_count     <= '0;
      timer        <= '0;
      shadow       <= '0;
      rd_count     <= '0;
      front_types  <= '0;
      overflow     <= 1'b0;
      protocol_err <= 1'b0;
      rd_data      <= '0;
    end else begin
      state <= state_nx;
      if (frame_start && state != IDLE) protocol_err <= 1'b1;
      case (state)
        REQUEST: begin
          wr_count <= '0;
          shadow   <= '0;
          timer    <= '0;
        end
        COLLECT: begin
          timer <= timer + 1'b1;
          if (timeout && !gen_done) protocol_err <= 1'b1;
          if (gen_valid) begin
            if (lane_bad) protocol_err <= 1'b1;
            else if (bank_full) overflow <= 1'b1;
            else begin
              wr_count <= wr_count + 1'b1;
              if (gen_first_row) shadow[int'(w_lane)*3 +: 3] <= w_type;
            end
          end
        end
        SWAP: begin
          front_sel   <= ~front_sel;
          rd_count    <= wr_count;
          front_types <= shadow;
        end
        default: ;
      endcase
      // Addresses past the published count read as zero so stale RAM never leaks out
      if (rd_addr < rd_count) rd_data <= front_sel ? bank1[rd_addr] : bank0[rd_addr];
      else                    rd_data <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && rst_n) begin
      if (front_sel) bank0[wr_count] <= gen_obstacle;
      else           bank1[wr_count] <= gen_obstacle;
    end
  end

endmodule

// File: tb/tb_obstacle_frame_collector.sv
// tb/tb_obstacle_frame_collector.sv - directed vector bench for obstacle_frame_collector
module tb_obstacle_frame_collector;
  localparam int MAXO = 48;
  localparam int TO   = 64;
  localparam int AW   = 6;

  logic          clk = 0;
  logic          rst_n = 0;
  logic          frame_start = 0, gen_valid = 0, gen_first_row = 0, gen_done = 0;
  logic [15:0]   gen_obstacle = 0;
  logic [AW-1:0] rd_addr = 0;
  logic          gen_activate, swap_pulse, busy, overflow, protocol_err;
  logic [15:0]   rd_data;
  logic [AW-1:0] rd_count;
  logic [8:0]    front_types;

  obstacle_frame_collector #(.MAX_OBSTACLES(MAXO), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .gen_activate(gen_activate),
    .gen_valid(gen_valid), .gen_first_row(gen_first_row), .gen_obstacle(gen_obstacle),
    .gen_done(gen_done), .rd_addr(rd_addr), .rd_data(rd_data), .rd_count(rd_count),
    .front_types(front_types), .swap_pulse(swap_pulse), .busy(busy),
    .overflow(overflow), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int act_cnt = 0, swap_cnt = 0;

  always @(negedge clk) begin
    if (gen_activate) act_cnt++;
    if (swap_pulse)   swap_cnt++;
  end

  typedef struct {
    logic [15:0] word;
    logic        first;
  } word_vec_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   exp;
  } rd_vec_t;

  word_vec_t f1_words [3];
  rd_vec_t   f1_reads [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic read_check(input string name, input logic [AW-1:0] a, input logic [15:0] exp);
    rd_addr = a;
    tick();
    check(name, 32'(rd_data), 32'(exp));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " gen_activate"}, 32'(gen_activate), 0);
    check({tag, " swap_pulse"},   32'(swap_pulse), 0);
    check({tag, " busy"},         32'(busy), 0);
    check({tag, " rd_data"},      32'(rd_data), 0);
    check({tag, " rd_count"},     32'(rd_count), 0);
    check({tag, " front_types"},  32'(front_types), 0);
    check({tag, " overflow"},     32'(overflow), 0);
    check({tag, " protocol_err"}, 32'(protocol_err), 0);
  endtask

  task automatic start_frame();
    frame_start = 1;
    tick();
    frame_start = 0;
    tick();
  endtask

  task automatic do_reset();
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  int a0, s0;

  initial begin
    f1_words[0] = '{{3'b100, 2'd0, 11'd100}, 1'b1};
    f1_words[1] = '{{3'b001, 2'd2, 11'd200}, 1'b1};
    f1_words[2] = '{{3'b011, 2'd2, 11'd300}, 1'b1};
    f1_reads[0] = '{6'd0, {3'b100, 2'd0, 11'd100}};
    f1_reads[1] = '{6'd1, {3'b001, 2'd2, 11'd200}};
    f1_reads[2] = '{6'd2, {3'b011, 2'd2, 11'd300}};
    f1_reads[3] = '{6'd3, 16'h0};

    tick(); tick();
    check_reset_outputs("reset");
    rst_n = 1;
    tick();

    // Frame 1: three words, activate latency, first-row types
    frame_start = 1;
    tick();
    check("f1 activate@N+1", 32'(gen_activate), 1);
    check("f1 busy request", 32'(busy), 1);
    frame_start = 0;
    tick();
    check("f1 activate one cycle", 32'(gen_activate), 0);
    for (int i = 0; i < 3; i++) begin
      gen_valid = 1; gen_obstacle = f1_words[i].word; gen_first_row = f1_words[i].first;
      tick();
    end
    gen_valid = 0; gen_first_row = 0; gen_done = 1;
    tick();
    check("f1 swap_pulse", 32'(swap_pulse), 1);
    gen_done = 0;
    tick();
    check("f1 swap_pulse cleared", 32'(swap_pulse), 0);
    check("f1 rd_count", 32'(rd_count), 3);
    check("f1 front_types", 32'(front_types), 32'(9'b011_000_100));
    check("f1 activate count", act_cnt, 1);
    check("f1 swap count", swap_cnt, 1);
    for (int i = 0; i < 4; i++)
      read_check($sformatf("f1 rd addr %0d", f1_reads[i].addr), f1_reads[i].addr, f1_reads[i].exp);

    // Frame 2: 50 words overflow the 48-word bank; read during SWAP sees old bank
    start_frame();
    for (int i = 0; i < 50; i++) begin
      gen_valid = 1; gen_first_row = 0;
      gen_obstacle = {3'b010, 2'(i % 3), 11'(i)};
      tick();
    end
    gen_valid = 0; gen_done = 1;
    tick();
    check("f2 swap_pulse", 32'(swap_pulse), 1);
    gen_done = 0; rd_addr = 6'd1;
    tick();
    check("f2 read in SWAP old bank", 32'(rd_data), 32'({3'b001, 2'd2, 11'd200}));
    check("f2 rd_count", 32'(rd_count), 48);
    check("f2 overflow", 32'(overflow), 1);
    check("f2 protocol_err", 32'(protocol_err), 0);
    check("f2 front_types", 32'(front_types), 0);
    read_check("f2 rd addr 0", 6'd0, {3'b010, 2'd0, 11'd0});
    read_check("f2 rd addr 47", 6'd47, {3'b010, 2'd2, 11'd47});
    read_check("f2 rd addr 48", 6'd48, 16'h0);

    // Frame 3: done never arrives
    s0 = swap_cnt;
    start_frame();
    repeat (TO - 1) tick();
    check("f3 busy last collect cycle", 32'(busy), 1);
    tick();
    check("f3 idle after timeout", 32'(busy), 0);
    check("f3 protocol_err", 32'(protocol_err), 1);
    check("f3 rd_count kept", 32'(rd_count), 48);
    check("f3 no swap", swap_cnt, s0);
    read_check("f3 rd addr 47 kept", 6'd47, {3'b010, 2'd2, 11'd47});

    // Frame 4: lane 3 word, frame_start while busy, valid with done
    do_reset();
    tick();
    check("f4 protocol_err after reset", 32'(protocol_err), 0);
    check("f4 rd_count after reset", 32'(rd_count), 0);
    a0 = act_cnt;
    start_frame();
    gen_valid = 1; gen_first_row = 1; gen_obstacle = {3'b001, 2'd3, 11'd5};
    tick();
    gen_valid = 0; gen_first_row = 0;
    check("f4 lane3 protocol_err", 32'(protocol_err), 1);
    frame_start = 1;
    tick();
    frame_start = 0;
    gen_valid = 1; gen_first_row = 1; gen_done = 1; gen_obstacle = {3'b101, 2'd1, 11'd77};
    tick();
    gen_valid = 0; gen_first_row = 0; gen_done = 0;
    check("f4 swap_pulse", 32'(swap_pulse), 1);
    tick();
    check("f4 rd_count", 32'(rd_count), 1);
    check("f4 front_types", 32'(front_types), 32'(9'b000_101_000));
    check("f4 single activate", act_cnt - a0, 1);
    read_check("f4 rd addr 0", 6'd0, {3'b101, 2'd1, 11'd77});
    read_check("f4 rd addr 1", 6'd1, 16'h0);

    // Reset mid-COLLECT, then a normal frame
    s0 = swap_cnt;
    start_frame();
    gen_valid = 1; gen_obstacle = {3'b110, 2'd0, 11'd9};
    tick();
    gen_valid = 0;
    rst_n = 0; rd_addr = 0;
    tick();
    check_reset_outputs("midreset");
    rst_n = 1;
    tick();
    check("midreset no swap", swap_cnt, s0);
    start_frame();
    gen_valid = 1; gen_obstacle = {3'b111, 2'd1, 11'd1};
    tick();
    gen_obstacle = {3'b010, 2'd0, 11'd2};
    tick();
    gen_valid = 0; gen_done = 1;
    tick();
    gen_done = 0;
    tick();
    check("f5 rd_count", 32'(rd_count), 2);
    check("f5 swap count", swap_cnt - s0, 1);
    read_check("f5 rd addr 0", 6'd0, {3'b111, 2'd1, 11'd1});
    read_check("f5 rd addr 1", 6'd1, {3'b010, 2'd0, 11'd2});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
